// File: rtl/riv_async_fifo_pkg.sv
// Shared types for the async FIFO pointer managers: the four-phase publish FSM state encoding.
package riv_async_fifo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_REQ   = 2'd2,
        ST_DRAIN = 2'd3
    } ptr_fsm_state_e;

endpackage : riv_async_fifo_pkg

// File: rtl/riv_async_fifo_ptr_fsm.sv
// Per-domain pointer manager: owns the local pointer, publishes snapshots via a four-phase handshake
// and derives full/empty. Optional occupancy output enabled by RIV_ASYNC_FIFO_PTR_FSM_LEVEL_EN.
module riv_async_fifo_ptr_fsm
    import riv_async_fifo_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter bit          WRITE_SIDE = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inc,
    output logic [ADDR_WIDTH-1:0] ptr,
    output logic                  stall,
    output logic [ADDR_WIDTH-1:0] level,
    output logic                  fsm_load,
    output logic                  fsm_req_ack,
    input  logic                  fsm_recv_ack,
    output logic [ADDR_WIDTH-1:0] local_addr,
    input  logic [ADDR_WIDTH-1:0] remote_addr
);

    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] PTR_HALF = {1'b1, {(ADDR_WIDTH-1){1'b0}}};

    ptr_fsm_state_e        state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0] sent_q, sent_d;
    logic                  load_q, load_d;
    logic                  req_q, req_d;
    logic [ADDR_WIDTH-1:0] diff_s;
    logic                  stall_s;

    // Full/empty from the registered local pointer and the (stale) remote pointer.
    always_comb begin
        diff_s = ptr_q - remote_addr;
        if (WRITE_SIDE) begin
            stall_s = (diff_s == PTR_HALF);
        end else begin
            stall_s = (ptr_q == remote_addr);
        end
    end

    // Pointer advance and handshake next-state; outputs are decoded from the next state so they leave a flop.
    always_comb begin
        ptr_d   = ptr_q;
        sent_d  = sent_q;
        state_d = state_q;
        if (inc && !stall_s) begin
            ptr_d = ptr_q + PTR_ONE;
        end else begin
            ptr_d = ptr_q;
        end
        case (state_q)
            ST_IDLE: begin
                // A lingering ack from before a reset must drop before a new publish starts.
                if ((ptr_q != sent_q) && !fsm_recv_ack) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                sent_d  = ptr_q;
                state_d = ST_REQ;
            end
            ST_REQ: begin
                if (fsm_recv_ack) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_DRAIN: begin
                if (!fsm_recv_ack) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        load_d = (state_d == ST_LOAD);
        req_d  = (state_d == ST_REQ);
    end

    // State, pointer and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= {ADDR_WIDTH{1'b0}};
            sent_q  <= {ADDR_WIDTH{1'b0}};
            load_q  <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sent_q  <= sent_d;
            load_q  <= load_d;
            req_q   <= req_d;
        end
    end

    assign ptr         = ptr_q;
    assign local_addr  = ptr_q;
    assign stall       = stall_s;
    assign fsm_load    = load_q;
    assign fsm_req_ack = req_q;

`ifdef RIV_ASYNC_FIFO_PTR_FSM_LEVEL_EN
    assign level = WRITE_SIDE ? diff_s : (remote_addr - ptr_q);
`else
    assign level = {ADDR_WIDTH{1'b0}};
`endif

endmodule : riv_async_fifo_ptr_fsm

// File: tb/tb_riv_async_fifo_ptr_fsm.sv
// Self-checking bench: write-side and read-side instances, loopback acknowledge, directed plus random phases.
module tb_riv_async_fifo_ptr_fsm;

    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          inc_w, inc_r;
    logic          ack_w, ack_r;
    logic [AW-1:0] rem_w, rem_r;
    logic [AW-1:0] ptr_w, ptr_r, level_w, level_r, laddr_w, laddr_r;
    logic          stall_w, stall_r, load_w, load_r, req_w, req_r;

    int            tests, fails;
    logic [AW-1:0] exp_w, exp_r;
    logic [7:0]    hist_w;
    int            dly;
    int            ack_mode;
    logic          ack_force;
    int            load_cnt;
    logic [AW-1:0] last_snap;
    logic          prev_load;

    always #5 clk = ~clk;

    riv_async_fifo_ptr_fsm #(.ADDR_WIDTH(AW), .WRITE_SIDE(1'b1)) dut_w (
        .clk(clk), .rst(rst), .inc(inc_w), .ptr(ptr_w), .stall(stall_w), .level(level_w),
        .fsm_load(load_w), .fsm_req_ack(req_w), .fsm_recv_ack(ack_w),
        .local_addr(laddr_w), .remote_addr(rem_w)
    );

    riv_async_fifo_ptr_fsm #(.ADDR_WIDTH(AW), .WRITE_SIDE(1'b0)) dut_r (
        .clk(clk), .rst(rst), .inc(inc_r), .ptr(ptr_r), .stall(stall_r), .level(level_r),
        .fsm_load(load_r), .fsm_req_ack(req_r), .fsm_recv_ack(ack_r),
        .local_addr(laddr_r), .remote_addr(rem_r)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_full_w();
        logic [AW-1:0] occ;
        occ = exp_w - rem_w;
        return (occ == 4'd8);
    endfunction

    function automatic logic [AW-1:0] model_level_w();
`ifdef RIV_ASYNC_FIFO_PTR_FSM_LEVEL_EN
        return exp_w - rem_w;
`else
        return 4'd0;
`endif
    endfunction

    function automatic logic [AW-1:0] model_level_r();
`ifdef RIV_ASYNC_FIFO_PTR_FSM_LEVEL_EN
        return rem_r - exp_r;
`else
        return 4'd0;
`endif
    endfunction

    // One clock: model update, acknowledge loopback, per-cycle checks.
    task automatic cycle();
        logic acc_w, acc_r;
        acc_w = inc_w && !model_full_w();
        acc_r = inc_r && (exp_r != rem_r);
        @(posedge clk);
        #1;
        if (rst) begin
            exp_w = 4'd0;
            exp_r = 4'd0;
        end else begin
            exp_w = exp_w + {3'b000, acc_w};
            exp_r = exp_r + {3'b000, acc_r};
        end
        hist_w = {hist_w[6:0], req_w};
        ack_w  = (ack_mode == 1) ? ack_force : hist_w[dly-1];
        ack_r  = req_r;
        chk("ptr_w", ptr_w, exp_w);
        chk("stall_w", stall_w, model_full_w());
        chk("level_w", level_w, model_level_w());
        chk("laddr_w", laddr_w, exp_w);
        chk("ptr_r", ptr_r, exp_r);
        chk("stall_r", stall_r, (exp_r == rem_r));
        chk("level_r", level_r, model_level_r());
        chk("excl_w", load_w & req_w, 1'b0);
        chk("excl_r", load_r & req_r, 1'b0);
        if (load_w) begin
            chk("load_once", prev_load, 1'b0);
            load_cnt++;
            last_snap = laddr_w;
        end
        prev_load = load_w;
    endtask

    initial begin
        int cnt;
        int lc;
        logic [AW-1:0] snap;
        logic [AW-1:0] lvl_exp;
        int occ;

        tests = 0; fails = 0;
        rst = 1'b1; inc_w = 1'b0; inc_r = 1'b0; rem_w = 4'd0; rem_r = 4'd0;
        ack_w = 1'b0; ack_r = 1'b0; ack_mode = 0; ack_force = 1'b0; dly = 2;
        hist_w = 8'd0; exp_w = 4'd0; exp_r = 4'd0; load_cnt = 0; last_snap = 4'd0; prev_load = 1'b0;

        // Reset state
        repeat (3) cycle();
        chk("rst_ptr", ptr_w, 4'd0);
        chk("rst_stall_w", stall_w, 1'b0);
        chk("rst_load", load_w, 1'b0);
        chk("rst_req", req_w, 1'b0);
        chk("rst_level", level_w, 4'd0);
        chk("rst_stall_r", stall_r, 1'b1);
        rst = 1'b0;
        cycle();

        // Single push with 2-cycle ack loopback
        inc_w = 1'b1;
        cycle();
        inc_w = 1'b0;
        chk("t2_ptr", ptr_w, 4'd1);
        chk("t2_noload", load_w, 1'b0);
        cycle();
        chk("t2_load", load_w, 1'b1);
        chk("t2_laddr", laddr_w, 4'd1);
        cycle();
        chk("t2_load_drop", load_w, 1'b0);
        chk("t2_req", req_w, 1'b1);
        cnt = 1;
        while (req_w && cnt < 20) begin
            cycle();
            if (req_w) cnt++;
        end
        chk("t2_req_len", cnt, dly);
        lc = load_cnt;
        repeat (8) cycle();
        chk("t2_no_reload", load_cnt, lc);
        chk("t2_idle_req", req_w, 1'b0);

        // Fill to full from an empty FIFO; ninth push dropped
        rst = 1'b1;
        repeat (2) cycle();
        rst = 1'b0;
        rem_w = 4'd0;
        inc_w = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            cycle();
            chk("t3_ptr", ptr_w, (i >= 8) ? 4'd8 : i[3:0]);
            chk("t3_stall", stall_w, (i >= 8));
        end
        inc_w = 1'b0;

        // Wrap across the pointer MSB
        rst = 1'b1;
        repeat (2) cycle();
        rst = 1'b0;
        inc_w = 1'b1;
        for (int i = 0; i < 14; i++) begin
            rem_w = exp_w;
            cycle();
        end
        chk("t4_start", ptr_w, 4'd14);
        rem_w = 4'd14;
        for (int i = 0; i < 9; i++) cycle();
        inc_w = 1'b0;
`ifdef RIV_ASYNC_FIFO_PTR_FSM_LEVEL_EN
        lvl_exp = 4'd8;
`else
        lvl_exp = 4'd0;
`endif
        chk("t4_ptr", ptr_w, 4'd6);
        chk("t4_stall", stall_w, 1'b1);
        chk("t4_level", level_w, lvl_exp);

        // Pushes while the request is outstanding are published afterwards
        rst = 1'b1;
        repeat (2) cycle();
        rst = 1'b0;
        rem_w = 4'd0;
        ack_mode = 1; ack_force = 1'b0; ack_w = 1'b0;
        repeat (4) cycle();
        inc_w = 1'b1;
        cycle();
        inc_w = 1'b0;
        cycle();
        chk("t5_load", load_w, 1'b1);
        snap = laddr_w;
        cycle();
        chk("t5_req", req_w, 1'b1);
        lc = load_cnt;
        inc_w = 1'b1;
        repeat (3) cycle();
        inc_w = 1'b0;
        repeat (6) cycle();
        chk("t5_req_held", req_w, 1'b1);
        chk("t5_no_load_in_req", load_cnt, lc);
        ack_mode = 0;
        cnt = 0;
        while (load_cnt == lc && cnt < 30) begin
            cycle();
            cnt++;
        end
        chk("t5_reload_seen", load_cnt - lc, 1);
        chk("t5_snap", last_snap, snap + 4'd3);
        repeat (10) cycle();

        // Reset in REQ while the ack is still high
        ack_mode = 1; ack_force = 1'b0; ack_w = 1'b0;
        inc_w = 1'b1;
        cycle();
        inc_w = 1'b0;
        cnt = 0;
        while (!req_w && cnt < 6) begin
            cycle();
            cnt++;
        end
        chk("t6_in_req", req_w, 1'b1);
        ack_force = 1'b1; ack_w = 1'b1;
        rst = 1'b1;
        repeat (2) cycle();
        rst = 1'b0;
        chk("t6_ptr", ptr_w, 4'd0);
        chk("t6_req", req_w, 1'b0);
        chk("t6_load", load_w, 1'b0);
        inc_w = 1'b1;
        cycle();
        inc_w = 1'b0;
        chk("t6_push", ptr_w, 4'd1);
        lc = load_cnt;
        repeat (5) cycle();
        chk("t6_hold_idle", load_cnt, lc);
        chk("t6_hold_req", req_w, 1'b0);
        ack_force = 1'b0; ack_w = 1'b0;
        cnt = 0;
        while (load_cnt == lc && cnt < 4) begin
            cycle();
            cnt++;
        end
        chk("t6_load_after_ack", load_cnt - lc, 1);
        chk("t6_snap", last_snap, 4'd1);
        ack_mode = 0;
        repeat (10) cycle();

        // Random traffic on both sides against the arithmetic model
        dly = 3;
        for (int n = 0; n < 400; n++) begin
            inc_w = ($urandom_range(0, 2) != 0);
            inc_r = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 3) == 0) begin
                occ = int'(4'(exp_w - rem_w));
                rem_w = rem_w + 4'($urandom_range(0, occ));
            end
            if ($urandom_range(0, 3) == 0) begin
                occ = 8 - int'(4'(rem_r - exp_r));
                rem_r = rem_r + 4'($urandom_range(0, occ));
            end
            cycle();
        end
        inc_w = 1'b0;
        inc_r = 1'b0;
        repeat (40) cycle();
        chk("t7_final_snap", last_snap, exp_w);
        chk("t7_final_req", req_w, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_riv_async_fifo_ptr_fsm
